// File: rtl/psc_trigger_scheduler.sv
// psc_trigger_scheduler: captures active-low trigger requests, arbitrates between
// them and issues one start/code handshake at a time to the trigger serializer,
// with an enforced hold-off gap after every frame and a saturating overrun counter.
// Build option: define PSC_SCHED_FIXED_PRIO_EN for fixed priority (source 0 highest)
// instead of round-robin; ports and timing are unchanged.
module psc_trigger_scheduler #(
    parameter int N_SRC   = 4,
    parameter int SRC_W   = 2,
    parameter int HOLDOFF = 1000,
    parameter int ACK_TO  = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_SRC-1:0] trig_n,
    output logic             tx_start,
    output logic [SRC_W-1:0] tx_src,
    output logic [7:0]       tx_seq,
    input  logic             tx_busy,
    output logic [N_SRC-1:0] pending,
    output logic [CNT_W-1:0] drop_count,
    output logic             ack_err,
    output logic             sched_busy
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_HOLDOFF   = 3'd4;

    // One timer serves both the ack timeout and the hold-off gap.
    localparam int TMAX = (HOLDOFF > ACK_TO) ? HOLDOFF : ACK_TO;
    localparam int TW   = $clog2(TMAX + 1);

    logic [N_SRC-1:0] sync1_q, sync2_q, hist_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             start_q, start_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [7:0]       seq_q, seq_d;
    logic             ack_q, ack_d;

    logic [N_SRC-1:0] fall, clr, drop;
    logic [3:0]       ndrop;
    logic [CNT_W+3:0] drop_sum;
    logic             gnt_vld;
    logic [SRC_W-1:0] gnt_idx;
    logic             do_grant;

    // Two-stage synchronizer plus history; reset to idle-high so release is edge-free.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            hist_q  <= '1;
        end else begin
            sync1_q <= trig_n;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign fall     = hist_q & ~sync2_q;
    assign do_grant = (state_q == S_IDLE) && enable && gnt_vld;

    // Pending update: a new edge wins over the ISSUE clear; edges on a still-pending source are drops.
    always_comb begin
        clr   = '0;
        ndrop = '0;
        for (int i = 0; i < N_SRC; i++)
            clr[i] = (state_q == S_ISSUE) && (src_q == SRC_W'(i));
        drop   = fall & pend_q & ~clr;
        pend_d = (pend_q & ~clr) | fall;
        for (int i = 0; i < N_SRC; i++)
            ndrop = ndrop + 4'(drop[i]);
        drop_sum = {4'b0, drop_q} + {{CNT_W{1'b0}}, ndrop};
        if (drop_sum > {4'b0, {CNT_W{1'b1}}})
            drop_d = '1;
        else
            drop_d = drop_sum[CNT_W-1:0];
    end

`ifdef PSC_SCHED_FIXED_PRIO_EN
    // Fixed priority: lowest pending index wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!gnt_vld && pend_q[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = SRC_W'(i);
            end
        end
    end
`else
    logic [SRC_W-1:0]   ptr_q;
    logic [2*N_SRC-1:0] dbl;
    logic [SRC_W:0]     widx;

    // Round-robin: rotate pending so bit 0 is ptr+1, take the first set bit, map back.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        widx    = '0;
        dbl     = {pend_q, pend_q} >> ({1'b0, ptr_q} + 1'b1);
        for (int k = 0; k < N_SRC; k++) begin
            if (!gnt_vld && dbl[k]) begin
                gnt_vld = 1'b1;
                widx    = {1'b0, ptr_q} + (SRC_W+1)'(k + 1);
                if (widx >= (SRC_W+1)'(N_SRC))
                    widx = widx - (SRC_W+1)'(N_SRC);
                gnt_idx = widx[SRC_W-1:0];
            end
        end
    end

    // Pointer remembers the last grant; reset value makes source 0 win first.
    always_ff @(posedge clk) begin
        if (!reset)
            ptr_q <= SRC_W'(N_SRC - 1);
        else if (do_grant)
            ptr_q <= gnt_idx;
    end
`endif

    // Frame sequencing FSM next-state logic.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        start_d = 1'b0;
        src_d   = src_q;
        seq_d   = seq_q;
        ack_d   = ack_q;
        case (state_q)
            S_IDLE: begin
                if (do_grant) begin
                    state_d = S_ISSUE;
                    start_d = 1'b1;
                    src_d   = gnt_idx;
                end
            end
            S_ISSUE: begin
                seq_d   = seq_q + 8'd1;
                tmr_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // ISSUE counts as the first of the ACK_TO cycles.
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmr_q == TW'(ACK_TO - 2)) begin
                    ack_d   = 1'b1;
                    tmr_d   = '0;
                    state_d = S_HOLDOFF;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    tmr_d   = '0;
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (tmr_q == TW'(HOLDOFF - 1))
                    state_d = S_IDLE;
                else
                    tmr_d = tmr_q + TW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            start_q <= 1'b0;
            src_q   <= '0;
            seq_q   <= '0;
            ack_q   <= 1'b0;
            pend_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            start_q <= start_d;
            src_q   <= src_d;
            seq_q   <= seq_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
        end
    end

    assign tx_start   = start_q;
    assign tx_src     = src_q;
    assign tx_seq     = seq_q;
    assign pending    = pend_q;
    assign drop_count = drop_q;
    assign ack_err    = ack_q;
    assign sched_busy = (state_q != S_IDLE);

endmodule
